// File: rtl/jt51_pkg.sv
// Shared constants for the jt51 CPU bus interface: register addresses,
// operator/channel range bases and the update-strobe selector encoding.
package jt51_pkg;

  // Global register addresses
  localparam logic [7:0] A_LFO_RST = 8'h01;
  localparam logic [7:0] A_KEYON   = 8'h08;
  localparam logic [7:0] A_NOISE   = 8'h0F;
  localparam logic [7:0] A_CLKA1   = 8'h10;
  localparam logic [7:0] A_CLKA2   = 8'h11;
  localparam logic [7:0] A_CLKB    = 8'h12;
  localparam logic [7:0] A_TIMER   = 8'h14;
  localparam logic [7:0] A_LFRQ    = 8'h18;
  localparam logic [7:0] A_PMDAMD  = 8'h19;
  localparam logic [7:0] A_CTW     = 8'h1B;

  // Channel ranges (8 bytes each)
  localparam logic [7:0] B_RL    = 8'h20;
  localparam logic [7:0] B_KC    = 8'h28;
  localparam logic [7:0] B_KF    = 8'h30;
  localparam logic [7:0] B_PMS   = 8'h38;
  // Operator/channel ranges (32 bytes each)
  localparam logic [7:0] B_DT1   = 8'h40;
  localparam logic [7:0] B_TL    = 8'h60;
  localparam logic [7:0] B_KS    = 8'h80;
  localparam logic [7:0] B_AMSEN = 8'hA0;
  localparam logic [7:0] B_DT2   = 8'hC0;
  localparam logic [7:0] B_D1L   = 8'hE0;

  // Busy window: counter loaded with 31 gives 32 cen cycles of strobe
  localparam int             BUSY_W    = 5;
  localparam logic [BUSY_W-1:0] BUSY_LOAD = 5'd31;

  typedef enum logic [3:0] {
    UPD_NONE  = 4'd0,
    UPD_KEYON = 4'd1,
    UPD_RL    = 4'd2,
    UPD_KC    = 4'd3,
    UPD_KF    = 4'd4,
    UPD_PMS   = 4'd5,
    UPD_DT1   = 4'd6,
    UPD_TL    = 4'd7,
    UPD_KS    = 4'd8,
    UPD_AMSEN = 4'd9,
    UPD_DT2   = 4'd10,
    UPD_D1L   = 4'd11
  } upd_e;

endpackage

// File: rtl/jt51_bus_dec.sv
// Combinational address decoder: maps a latched register address to the
// per-register update selector plus the operator and channel it targets.
module jt51_bus_dec
  import jt51_pkg::*;
(
  input  logic [7:0] addr_i,
  output logic [3:0] sel_o,
  output logic [1:0] op_o,
  output logic [2:0] ch_o
);

  // Range compare from the top down; globals below 0x20 only hit keyon here
  always_comb begin
    sel_o = UPD_NONE;
    op_o  = 2'd0;
    ch_o  = 3'd0;
    if (addr_i >= B_DT1) begin
      op_o = addr_i[4:3];
      ch_o = addr_i[2:0];
      if      (addr_i >= B_D1L)   sel_o = UPD_D1L;
      else if (addr_i >= B_DT2)   sel_o = UPD_DT2;
      else if (addr_i >= B_AMSEN) sel_o = UPD_AMSEN;
      else if (addr_i >= B_KS)    sel_o = UPD_KS;
      else if (addr_i >= B_TL)    sel_o = UPD_TL;
      else                        sel_o = UPD_DT1;
    end else if (addr_i >= B_RL) begin
      ch_o = addr_i[2:0];
      if      (addr_i >= B_PMS) sel_o = UPD_PMS;
      else if (addr_i >= B_KF)  sel_o = UPD_KF;
      else if (addr_i >= B_KC)  sel_o = UPD_KC;
      else                      sel_o = UPD_RL;
    end else if (addr_i == A_KEYON) begin
      sel_o = UPD_KEYON;
    end
  end

endmodule

// File: rtl/jt51_bus_if.sv
// jt51 CPU bus interface: edge-detects CPU writes, latches address/data,
// drives a 32-cen per-register update window and holds the global registers.
module jt51_bus_if
  import jt51_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic       flag_A,
  input  logic       flag_B,
  output logic [7:0] dout,
  output logic [7:0] d_reg,
  output logic       up_rl,
  output logic       up_kc,
  output logic       up_kf,
  output logic       up_pms,
  output logic       up_dt1,
  output logic       up_tl,
  output logic       up_ks,
  output logic       up_amsen,
  output logic       up_dt2,
  output logic       up_d1l,
  output logic       up_keyon,
  output logic [1:0] op,
  output logic [2:0] ch,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       en_irqA,
  output logic       en_irqB,
  output logic       csm,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic [7:0] lfrq,
  output logic [6:0] amd,
  output logic [6:0] pmd,
  output logic [1:0] w,
  output logic [1:0] ct,
  output logic       ne,
  output logic [4:0] nfrq,
  output logic       lfo_rst
);

  // ---- write capture (clk domain, not gated by cen) ----
  logic       wr_now, wr_edge, wr_go, wr_a0;
  logic [7:0] wr_din;
  logic       wr_last_q, pend_q, pend_a0_q;
  logic [7:0] pend_din_q;

  assign wr_now  = ~cs_n & ~wr_n;
  assign wr_edge = wr_now & ~wr_last_q;
  // A fresh edge on a cen cycle wins over anything pending
  assign wr_go   = cen & (wr_edge | pend_q);
  assign wr_a0   = wr_edge ? a0  : pend_a0_q;
  assign wr_din  = wr_edge ? din : pend_din_q;

  // Sample the strobe every clk; park an edge that lands off-cen until the next cen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_last_q  <= 1'b0;
      pend_q     <= 1'b0;
      pend_a0_q  <= 1'b0;
      pend_din_q <= 8'd0;
    end else begin
      wr_last_q <= wr_now;
      if (wr_edge) begin
        pend_a0_q  <= a0;
        pend_din_q <= din;
      end
      if (cen)          pend_q <= 1'b0;
      else if (wr_edge) pend_q <= 1'b1;
    end
  end

  // ---- address decode ----
  logic [7:0]        addr_q, addr_d;
  logic [3:0]        dec_sel;
  logic [1:0]        dec_op;
  logic [2:0]        dec_ch;

  jt51_bus_dec u_dec (
    .addr_i (addr_q),
    .sel_o  (dec_sel),
    .op_o   (dec_op),
    .ch_o   (dec_ch)
  );

  // ---- update engine state ----
  upd_e              upd_q, upd_d;
  logic              busy_q, busy_d;
  logic [BUSY_W-1:0] cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [2:0]        ch_q, ch_d;
  logic [7:0]        dreg_q, dreg_d;
  logic              data_wr;

  // Next state: count down the busy window, then accept address/data writes
  always_comb begin
    addr_d  = addr_q;
    dreg_d  = dreg_q;
    upd_d   = upd_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ch_d    = ch_q;
    data_wr = 1'b0;
    if (cen && busy_q) begin
      if (cnt_q == '0) begin
        upd_d  = UPD_NONE;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    if (wr_go) begin
      if (!wr_a0) begin
        addr_d = wr_din;
      end else if (!busy_q) begin
        data_wr = 1'b1;
        dreg_d  = wr_din;
        if (upd_e'(dec_sel) != UPD_NONE) begin
          upd_d  = upd_e'(dec_sel);
          busy_d = 1'b1;
          cnt_d  = BUSY_LOAD;
          op_d   = dec_op;
          ch_d   = dec_ch;
        end
      end
    end
  end

  // Update engine registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= 8'd0;
      dreg_q <= 8'd0;
      upd_q  <= UPD_NONE;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= 2'd0;
      ch_q   <= 3'd0;
    end else begin
      addr_q <= addr_d;
      dreg_q <= dreg_d;
      upd_q  <= upd_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      ch_q   <= ch_d;
    end
  end

  // ---- global registers ----
  logic [9:0] val_a_q;
  logic [7:0] val_b_q, lfrq_q;
  logic [6:0] amd_q, pmd_q;
  logic [1:0] w_q, ct_q;
  logic [4:0] nfrq_q;
  logic       ne_q, lfo_rst_q, csm_q, irqb_q, irqa_q, ldb_q, lda_q, clra_q, clrb_q;

  // Global writes land on the executing cen; flag clears are one-cen pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_a_q   <= 10'd0;
      val_b_q   <= 8'd0;
      lfrq_q    <= 8'd0;
      amd_q     <= 7'd0;
      pmd_q     <= 7'd0;
      w_q       <= 2'd0;
      ct_q      <= 2'd0;
      nfrq_q    <= 5'd0;
      ne_q      <= 1'b0;
      lfo_rst_q <= 1'b0;
      csm_q     <= 1'b0;
      irqb_q    <= 1'b0;
      irqa_q    <= 1'b0;
      ldb_q     <= 1'b0;
      lda_q     <= 1'b0;
      clra_q    <= 1'b0;
      clrb_q    <= 1'b0;
    end else if (cen) begin
      clra_q <= 1'b0;
      clrb_q <= 1'b0;
      if (data_wr) begin
        case (addr_q)
          A_LFO_RST: lfo_rst_q <= wr_din[1];
          A_NOISE: begin
            ne_q   <= wr_din[7];
            nfrq_q <= wr_din[4:0];
          end
          A_CLKA1: val_a_q[9:2] <= wr_din;
          A_CLKA2: val_a_q[1:0] <= wr_din[1:0];
          A_CLKB:  val_b_q      <= wr_din;
          A_TIMER: begin
            csm_q  <= wr_din[7];
            clrb_q <= wr_din[5];
            clra_q <= wr_din[4];
            irqb_q <= wr_din[3];
            irqa_q <= wr_din[2];
            ldb_q  <= wr_din[1];
            lda_q  <= wr_din[0];
          end
          A_LFRQ: lfrq_q <= wr_din;
          A_PMDAMD: begin
            if (wr_din[7]) pmd_q <= wr_din[6:0];
            else           amd_q <= wr_din[6:0];
          end
          A_CTW: begin
            ct_q <= wr_din[7:6];
            w_q  <= wr_din[1:0];
          end
          default: ;
        endcase
      end
    end
  end

  // ---- outputs ----
  assign dout     = {busy_q, 5'b00000, flag_B, flag_A};
  assign d_reg    = dreg_q;
  assign op       = op_q;
  assign ch       = ch_q;
  assign up_keyon = (upd_q == UPD_KEYON);
  assign up_rl    = (upd_q == UPD_RL);
  assign up_kc    = (upd_q == UPD_KC);
  assign up_kf    = (upd_q == UPD_KF);
  assign up_pms   = (upd_q == UPD_PMS);
  assign up_dt1   = (upd_q == UPD_DT1);
  assign up_tl    = (upd_q == UPD_TL);
  assign up_ks    = (upd_q == UPD_KS);
  assign up_amsen = (upd_q == UPD_AMSEN);
  assign up_dt2   = (upd_q == UPD_DT2);
  assign up_d1l   = (upd_q == UPD_D1L);

  assign value_A    = val_a_q;
  assign value_B    = val_b_q;
  assign load_A     = lda_q;
  assign load_B     = ldb_q;
  assign en_irqA    = irqa_q;
  assign en_irqB    = irqb_q;
  assign csm        = csm_q;
  assign clr_flag_A = clra_q;
  assign clr_flag_B = clrb_q;
  assign lfrq       = lfrq_q;
  assign amd        = amd_q;
  assign pmd        = pmd_q;
  assign w          = w_q;
  assign ct         = ct_q;
  assign ne         = ne_q;
  assign nfrq       = nfrq_q;
  assign lfo_rst    = lfo_rst_q;

endmodule
